// File: rtl/seg_scan_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_rx_if
// Description : Scanned 7-segment display bus plus the receiver's decoded
//               outputs. The master drives the scan (digit enable, segment
//               lines, error clear). The slave (seg_scan_rx) returns the
//               captured frame.
// Signals     : dig_en[3:0]  one-hot digit enable (other values = blanking)
//               seg[6:0]     segment lines a..g, active high
//               clr_err      clears the sticky bad-pattern flag
//               digits[15:0] captured frame, slot i at [4i+3:4i]
//               frame_vld    one-cycle strobe on frame completion
//               bad_pat      sticky illegal-glyph flag
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_rx_if;
  logic [3:0]  dig_en;
  logic [6:0]  seg;
  logic        clr_err;
  logic [15:0] digits;
  logic        frame_vld;
  logic        bad_pat;

  modport master (
    output dig_en, seg, clr_err,
    input  digits, frame_vld, bad_pat
  );

  modport slave (
    input  dig_en, seg, clr_err,
    output digits, frame_vld, bad_pat
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_rx.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_rx
// Description : Receive side of a multiplexed 7-segment display. It
//               debounces each digit's segment pattern, decodes it back to
//               a hex nibble and assembles a 4-slot frame with a one-cycle
//               valid strobe.
// Ports       : clk    system clock, rising edge
//               rst_n  synchronous active-low reset
//               bus    seg_scan_rx_if.slave (dig_en, seg, clr_err in;
//                      digits, frame_vld, bad_pat out)
// Parameters  : STABLE_CYC  identical samples needed to accept (2..255)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_rx #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_scan_rx_if.slave bus
);

  localparam logic [7:0] C_STABLE = 8'(STABLE_CYC);

  // smp_q is the registered sample; prev_q is the sample before it.
  logic [10:0] smp_q,    smp_d;
  logic [10:0] prev_q,   prev_d;
  logic [7:0]  cnt_q,    cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  cap_q,    cap_d;
  logic        vld_q,    vld_d;
  logic        bad_q,    bad_d;

  logic        hit;
  logic        slot_ok;
  logic [1:0]  slot;
  logic        legal;
  logic [3:0]  val;
  logic        accept;
  logic [3:0]  cap_nxt;

  // Slot select from the registered digit enable; anything not one-hot
  // is blanking and never accepted.
  always_comb begin
    slot    = 2'd0;
    slot_ok = 1'b0;
    case (smp_q[10:7])
      4'b0001: begin slot = 2'd0; slot_ok = 1'b1; end
      4'b0010: begin slot = 2'd1; slot_ok = 1'b1; end
      4'b0100: begin slot = 2'd2; slot_ok = 1'b1; end
      4'b1000: begin slot = 2'd3; slot_ok = 1'b1; end
      default: begin slot = 2'd0; slot_ok = 1'b0; end
    endcase
  end

  // Glyph decode of the registered segment pattern.
  always_comb begin
    val   = 4'h0;
    legal = 1'b1;
    case (smp_q[6:0])
      7'h3F: val = 4'h0;
      7'h06: val = 4'h1;
      7'h5B: val = 4'h2;
      7'h4F: val = 4'h3;
      7'h66: val = 4'h4;
      7'h6D: val = 4'h5;
      7'h7D: val = 4'h6;
      7'h07: val = 4'h7;
      7'h7F: val = 4'h8;
      7'h6F: val = 4'h9;
      7'h77: val = 4'hA;
      7'h7C: val = 4'hB;
      7'h39: val = 4'hC;
      7'h5E: val = 4'hD;
      7'h79: val = 4'hE;
      7'h71: val = 4'hF;
      default: begin
        val   = 4'h0;
        legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    smp_d    = {bus.dig_en, bus.seg};
    prev_d   = smp_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    cap_d    = cap_q;
    vld_d    = 1'b0;
    bad_d    = bad_q;
    cap_nxt  = cap_q;

    // Run-length of the registered sample, saturating at STABLE_CYC.
    if (smp_q == prev_q) begin
      if (cnt_q < C_STABLE) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = 8'd1;
    end

    // Accept only on the step into saturation so a long dwell counts once.
    hit    = (cnt_d == C_STABLE) && (cnt_q != C_STABLE);
    accept = hit && slot_ok;

    if (accept) begin
      digits_d[{slot, 2'b00} +: 4] = legal ? val : 4'h0;
      cap_nxt = cap_q | (4'b0001 << slot);
      if (cap_nxt == 4'hF) begin
        vld_d = 1'b1;
        cap_d = 4'h0;
      end else begin
        cap_d = cap_nxt;
      end
    end

    // A new bad acceptance beats a simultaneous clear.
    if (accept && !legal) begin
      bad_d = 1'b1;
    end else if (bus.clr_err) begin
      bad_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      cap_q    <= '0;
      vld_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      smp_q    <= smp_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      cap_q    <= cap_d;
      vld_q    <= vld_d;
      bad_q    <= bad_d;
    end
  end

  assign bus.digits    = digits_q;
  assign bus.frame_vld = vld_q;
  assign bus.bad_pat   = bad_q;

endmodule
`default_nettype wire
